filter_cfg_ctrl: RTL and testbench

- Configuration and sequencing controller placed in front of the FIR filter block.
- Holds a coefficient bank written by the host, and owns the filter's coefficient-load sequence: start pulse, coefficient stream with tlast, wait for lddone.
- Between loads it gates the audio sample stream into the filter, so a reload never splits an audio packet.
- Error, timeout and illegal-order conditions are reported through a sticky error flag.

---
 rtl/filter_ctrl_pkg.sv | 24 ++
 rtl/coeff_bank.sv | 30 +++
 rtl/filter_cfg_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_filter_cfg_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient-load controller.
package filter_ctrl_pkg;

  // Width of the filter-order field shared with the FIR block.
  localparam int ORD_W = 10;

  // Cycles to wait for the filter's load-complete status before giving up.
  localparam int DEFAULT_LD_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_RUN,
    ST_DRAIN
  } cfg_state_t;

  // Only the two resting states accept host bank writes.
  function automatic logic is_busy(input cfg_state_t s);
    return !((s == ST_IDLE) || (s == ST_RUN));
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// Single-port coefficient register file with synchronous, enable-gated read.
// Holding re_i low keeps rdata_o stable, which the controller relies on
// to hold a stalled beat.
module coeff_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 512
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port and registered read port share one address.
  // NOTE: the array and read register carry no reset; a memory reset would
  // prevent RAM inference, and their contents are only observed after a write
  // and a qualified read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/filter_cfg_ctrl.sv
// Coefficient-load sequencer and audio gate in front of the FIR filter.
// Streams bank[0..ord] into the filter, waits for lddone, then passes audio
// through; reloads are deferred to packet boundaries.
module filter_cfg_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_TAPS   = 512,
  parameter int LD_TIMEOUT = DEFAULT_LD_TIMEOUT
) (
  input  logic                        pi_clk,
  input  logic                        pi_sreset,
  // host coefficient writes (two's-complement data)
  input  logic                        pi_cwr_en,
  input  logic [$clog2(MAX_TAPS)-1:0] pi_cwr_addr,
  input  logic signed [DATA_WIDTH-1:0] pi_cwr_data,
  input  logic                        pi_reload,
  input  logic [ORD_W-1:0]            pi_filt_ord,
  // upstream audio stream
  input  logic [DATA_WIDTH-1:0]       pi_audio_tdata,
  input  logic                        pi_audio_tvalid,
  input  logic                        pi_audio_tlast,
  output logic                        po_audio_tready,
  // filter data input (coefficients or samples)
  output logic [DATA_WIDTH-1:0]       po_filt_tdata,
  output logic                        po_filt_tvalid,
  output logic                        po_filt_tlast,
  input  logic                        pi_filt_tready,
  // filter control / status
  output logic                        po_filt_start_c_load,
  output logic [ORD_W-1:0]            po_filt_ord,
  input  logic                        pi_filt_lddone,
  input  logic                        pi_filt_err,
  output logic                        po_busy,
  output logic                        po_cfg_done,
  output logic                        po_err
);

  localparam int AW = $clog2(MAX_TAPS);
  localparam int TW = $clog2(LD_TIMEOUT) + 1;

  cfg_state_t            state_q, state_d;
  logic [ORD_W-1:0]      ord_q, ord_d, pend_ord_q, pend_ord_d, next_ord;
  logic                  pend_q, pend_d, err_q, err_d, done_q, done_d;
  logic                  in_pkt_q, in_pkt_d;
  logic [AW-1:0]         beat_q, beat_d, bank_addr;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  bank_we, bank_re;
  logic [DATA_WIDTH-1:0] bank_rdata, filt_tdata;
  logic                  filt_tvalid, filt_tlast, audio_tready, start_pulse;
  logic                  ord_ok, reload_ok, reload_bad, reload_req, go_start, audio_hs;

  coeff_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_TAPS)
  ) u_bank (
    .clk_i   (pi_clk),
    .we_i    (bank_we),
    .re_i    (bank_re),
    .addr_i  (bank_addr),
    .wdata_i (pi_cwr_data),
    .rdata_o (bank_rdata)
  );

  assign ord_ok     = (pi_filt_ord <= ORD_W'(MAX_TAPS - 1));
  assign reload_ok  = pi_reload && ord_ok;
  assign reload_bad = pi_reload && !ord_ok;
  assign reload_req = reload_ok || pend_q;
  assign next_ord   = reload_ok ? pi_filt_ord : pend_ord_q;
  assign audio_hs   = pi_audio_tvalid && pi_filt_tready;

  // Next-state, bank port steering and stream muxing.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    ord_d        = ord_q;
    pend_d       = pend_q;
    pend_ord_d   = pend_ord_q;
    beat_d       = beat_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    done_d       = 1'b0;
    in_pkt_d     = in_pkt_q;
    go_start     = 1'b0;
    bank_we      = pi_cwr_en && !is_busy(state_q);
    bank_re      = 1'b0;
    bank_addr    = pi_cwr_addr;
    filt_tdata   = '0;
    filt_tvalid  = 1'b0;
    filt_tlast   = 1'b0;
    audio_tready = 1'b0;
    start_pulse  = 1'b0;

    // Outside IDLE a legal reload is remembered; an illegal one only flags.
    if (state_q != ST_IDLE) begin
      if (reload_ok) begin
        pend_d     = 1'b1;
        pend_ord_d = pi_filt_ord;
      end
      if (reload_bad) err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (reload_bad) begin
          err_d = 1'b1;
        end else if (reload_ok) begin
          go_start = 1'b1;
        end
      end

      ST_START: begin
        start_pulse = 1'b1;
        bank_re     = 1'b1;
        bank_addr   = '0;
        beat_d      = '0;
        state_d     = ST_LOAD;
      end

      ST_LOAD: begin
        filt_tvalid = 1'b1;
        filt_tdata  = bank_rdata;
        filt_tlast  = (ORD_W'(beat_q) == ord_q);
        if (pi_filt_tready) begin
          if (filt_tlast) begin
            tmo_d   = '0;
            state_d = ST_WAIT_DONE;
          end else begin
            // Prefetch the next coefficient; a stall leaves rdata untouched.
            bank_re   = 1'b1;
            bank_addr = beat_q + AW'(1);
            beat_d    = beat_q + AW'(1);
          end
        end
      end

      ST_WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        if (pi_filt_lddone) begin
          done_d  = 1'b1;
          state_d = ST_RUN;
        end else if (pi_filt_err || (tmo_d == TW'(LD_TIMEOUT))) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if ((state_q == ST_RUN) && reload_req && !in_pkt_q && !pi_filt_err) begin
          // At a packet boundary: block this cycle's beat and reload now.
          go_start = 1'b1;
        end else begin
          filt_tdata   = pi_audio_tdata;
          filt_tvalid  = pi_audio_tvalid;
          filt_tlast   = pi_audio_tlast;
          audio_tready = pi_filt_tready;
          if (audio_hs) in_pkt_d = !pi_audio_tlast;
          if (pi_filt_err) begin
            err_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = ST_IDLE;
          end else if ((state_q == ST_DRAIN) || reload_req) begin
            if (audio_hs && pi_audio_tlast) go_start = 1'b1;
            else                            state_d  = ST_DRAIN;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Accepting a reload latches the order and clears the sticky error.
    if (go_start) begin
      ord_d   = next_ord;
      err_d   = reload_bad;
      pend_d  = 1'b0;
      state_d = ST_START;
    end
  end

  // Controller state registers with asynchronous reset.
  always_ff @(posedge pi_clk or posedge pi_sreset) begin
    if (pi_sreset) begin
      state_q    <= ST_IDLE;
      ord_q      <= '0;
      pend_q     <= 1'b0;
      pend_ord_q <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      in_pkt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ord_q      <= ord_d;
      pend_q     <= pend_d;
      pend_ord_q <= pend_ord_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      done_q     <= done_d;
      in_pkt_q   <= in_pkt_d;
    end
  end

  assign po_filt_tdata        = filt_tdata;
  assign po_filt_tvalid       = filt_tvalid;
  assign po_filt_tlast        = filt_tlast;
  assign po_audio_tready      = audio_tready;
  assign po_filt_start_c_load = start_pulse;
  assign po_filt_ord          = ord_q;
  assign po_busy              = is_busy(state_q);
  assign po_cfg_done          = done_q;
  assign po_err               = err_q;

endmodule

// File: tb/tb_filter_cfg_ctrl.sv
// Directed bench for filter_cfg_ctrl: loads, stalls, drain, errors, timeout, reset.
module tb_filter_cfg_ctrl;
  import filter_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int MAX_TAPS = 512;
  localparam int AW = 9;
  localparam int LD_TIMEOUT = 1024;

  logic              pi_clk = 1'b0;
  logic              pi_sreset;
  logic              pi_cwr_en;
  logic [AW-1:0]     pi_cwr_addr;
  logic [DW-1:0]     pi_cwr_data;
  logic              pi_reload;
  logic [ORD_W-1:0]  pi_filt_ord;
  logic [DW-1:0]     pi_audio_tdata;
  logic              pi_audio_tvalid, pi_audio_tlast, po_audio_tready;
  logic [DW-1:0]     po_filt_tdata;
  logic              po_filt_tvalid, po_filt_tlast, pi_filt_tready;
  logic              po_filt_start_c_load;
  logic [ORD_W-1:0]  po_filt_ord;
  logic              pi_filt_lddone, pi_filt_err;
  logic              po_busy, po_cfg_done, po_err;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] coef [4];

  always #5 pi_clk = ~pi_clk;

  filter_cfg_ctrl #(
    .DATA_WIDTH (DW),
    .MAX_TAPS   (MAX_TAPS),
    .LD_TIMEOUT (LD_TIMEOUT)
  ) dut (
    .pi_clk               (pi_clk),
    .pi_sreset            (pi_sreset),
    .pi_cwr_en            (pi_cwr_en),
    .pi_cwr_addr          (pi_cwr_addr),
    .pi_cwr_data          (pi_cwr_data),
    .pi_reload            (pi_reload),
    .pi_filt_ord          (pi_filt_ord),
    .pi_audio_tdata       (pi_audio_tdata),
    .pi_audio_tvalid      (pi_audio_tvalid),
    .pi_audio_tlast       (pi_audio_tlast),
    .po_audio_tready      (po_audio_tready),
    .po_filt_tdata        (po_filt_tdata),
    .po_filt_tvalid       (po_filt_tvalid),
    .po_filt_tlast        (po_filt_tlast),
    .pi_filt_tready       (pi_filt_tready),
    .po_filt_start_c_load (po_filt_start_c_load),
    .po_filt_ord          (po_filt_ord),
    .pi_filt_lddone       (pi_filt_lddone),
    .pi_filt_err          (pi_filt_err),
    .po_busy              (po_busy),
    .po_cfg_done          (po_cfg_done),
    .po_err               (po_err)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge pi_clk);
    #1;
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pi_cwr_en = 1'b1; pi_cwr_addr = a; pi_cwr_data = d;
    tick();
    pi_cwr_en = 1'b0;
  endtask

  task automatic test_reset();
    pi_sreset = 1'b1; pi_cwr_en = 1'b0; pi_cwr_addr = '0; pi_cwr_data = '0;
    pi_reload = 1'b0; pi_filt_ord = '0; pi_audio_tdata = 16'h5555;
    pi_audio_tvalid = 1'b1; pi_audio_tlast = 1'b0; pi_filt_tready = 1'b1;
    pi_filt_lddone = 1'b0; pi_filt_err = 1'b0;
    #2;
    checks++;
    if ({po_filt_start_c_load, po_busy, po_cfg_done, po_err, po_filt_tvalid, po_filt_tlast, po_audio_tready} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {po_filt_start_c_load, po_busy, po_cfg_done, po_err, po_filt_tvalid, po_filt_tlast, po_audio_tready});
    end
    checks++;
    if ({po_filt_ord, po_filt_tdata} !== 26'd0) begin
      failures++; $display("FAIL reset_data got ord=%h tdata=%h exp 0", po_filt_ord, po_filt_tdata);
    end
    repeat (2) @(posedge pi_clk);
    #3 pi_sreset = 1'b0;
    pi_audio_tvalid = 1'b0;
    tick();
    checks++;
    if ({po_busy, po_err, po_audio_tready} !== 3'b000) begin
      failures++; $display("FAIL reset_release got=%b exp=000", {po_busy, po_err, po_audio_tready});
    end
  endtask

  task automatic test_bad_order();
    pi_filt_ord = 10'd600; pi_reload = 1'b1; pi_audio_tvalid = 1'b1;
    tick();
    pi_reload = 1'b0;
    checks++;
    if ({po_err, po_filt_start_c_load, po_busy, po_audio_tready} !== 4'b1000) begin
      failures++; $display("FAIL bad_order got err/start/busy/tready=%b exp=1000", {po_err, po_filt_start_c_load, po_busy, po_audio_tready});
    end
    checks++;
    if (po_filt_ord !== 10'd0) begin
      failures++; $display("FAIL bad_order_latch got=%0d exp=0", po_filt_ord);
    end
    tick();
    checks++;
    if ({po_err, po_filt_start_c_load} !== 2'b10) begin
      failures++; $display("FAIL bad_order_hold got err/start=%b exp=10", {po_err, po_filt_start_c_load});
    end
    pi_audio_tvalid = 1'b0;
  endtask

  task automatic test_load_basic();
    for (int i = 0; i < 4; i++) write_coef(AW'(i), coef[i]);
    pi_filt_tready = 1'b1; pi_filt_ord = 10'd3; pi_reload = 1'b1;
    tick();
    pi_reload = 1'b0;
    checks++;
    if ({po_filt_start_c_load, po_busy, po_err, po_filt_tvalid} !== 4'b1100) begin
      failures++; $display("FAIL basic_start got start/busy/err/tvalid=%b exp=1100", {po_filt_start_c_load, po_busy, po_err, po_filt_tvalid});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({po_filt_start_c_load, po_filt_tvalid, po_filt_tlast, po_filt_tdata} !== {1'b0, 1'b1, (i == 3), coef[i]}) begin
        failures++; $display("FAIL basic_beat%0d got start=%b v=%b l=%b d=%h exp d=%h", i, po_filt_start_c_load, po_filt_tvalid, po_filt_tlast, po_filt_tdata, coef[i]);
      end
      tick();
    end
    checks++;
    if ({po_filt_tvalid, po_busy, po_filt_ord} !== {2'b01, 10'd3}) begin
      failures++; $display("FAIL basic_wait got v=%b busy=%b ord=%0d exp 0/1/3", po_filt_tvalid, po_busy, po_filt_ord);
    end
    repeat (4) tick();
    pi_filt_lddone = 1'b1;
    tick();
    pi_filt_lddone = 1'b0;
    checks++;
    if ({po_cfg_done, po_busy} !== 2'b10) begin
      failures++; $display("FAIL basic_done got done/busy=%b exp=10", {po_cfg_done, po_busy});
    end
    tick();
    checks++;
    if (po_cfg_done !== 1'b0) begin
      failures++; $display("FAIL basic_done_pulse got=%b exp=0", po_cfg_done);
    end
  endtask

  task automatic test_load_stall();
    logic [3:0] pat;
    int idx, cyc;
    pat = 4'b1001; idx = 0; cyc = 0;
    checks++;
    if (po_audio_tready !== 1'b1) begin
      failures++; $display("FAIL stall_run_tready got=%b exp=1", po_audio_tready);
    end
    pi_filt_ord = 10'd3; pi_reload = 1'b1;
    #1;
    checks++;
    if (po_audio_tready !== 1'b0) begin
      failures++; $display("FAIL stall_gate got=%b exp=0", po_audio_tready);
    end
    tick();
    pi_reload = 1'b0;
    checks++;
    if (po_filt_start_c_load !== 1'b1) begin
      failures++; $display("FAIL stall_start got=%b exp=1", po_filt_start_c_load);
    end
    tick();
    while (idx < 4 && cyc < 20) begin
      pi_filt_tready = pat[cyc % 4];
      #1;
      checks++;
      if ({po_filt_tvalid, po_filt_tlast, po_filt_tdata} !== {1'b1, (idx == 3), coef[idx]}) begin
        failures++; $display("FAIL stall_c%0d got v=%b l=%b d=%h exp beat%0d d=%h", cyc, po_filt_tvalid, po_filt_tlast, po_filt_tdata, idx, coef[idx]);
      end
      if (pi_filt_tready) idx++;
      cyc++;
      tick();
    end
    pi_filt_tready = 1'b1;
    checks++;
    if ({po_filt_tvalid, po_busy} !== 2'b01 || cyc != 8) begin
      failures++; $display("FAIL stall_end got v=%b busy=%b cycles=%0d exp 0/1/8", po_filt_tvalid, po_busy, cyc);
    end
    pi_filt_lddone = 1'b1;
    tick();
    pi_filt_lddone = 1'b0;
    checks++;
    if (po_cfg_done !== 1'b1) begin
      failures++; $display("FAIL stall_done got=%b exp=1", po_cfg_done);
    end
  endtask

  task automatic test_drain();
    pi_filt_tready = 1'b1; pi_filt_ord = 10'd1;
    for (int i = 0; i < 8; i++) begin
      pi_audio_tvalid = 1'b1; pi_audio_tdata = 16'h0100 + DW'(i);
      pi_audio_tlast = (i == 7); pi_reload = (i == 3);
      #1;
      checks++;
      if ({po_filt_tvalid, po_filt_tlast, po_audio_tready, po_busy, po_filt_tdata} !== {1'b1, (i == 7), 1'b1, (i >= 4), 16'h0100 + DW'(i)}) begin
        failures++; $display("FAIL drain_s%0d got v=%b l=%b rdy=%b busy=%b d=%h", i, po_filt_tvalid, po_filt_tlast, po_audio_tready, po_busy, po_filt_tdata);
      end
      tick();
    end
    pi_reload = 1'b0;
    pi_audio_tvalid = 1'b1; pi_audio_tdata = 16'h0200; pi_audio_tlast = 1'b0;
    #1;
    checks++;
    if ({po_filt_start_c_load, po_audio_tready, po_filt_tvalid, po_filt_ord} !== {3'b100, 10'd1}) begin
      failures++; $display("FAIL drain_start got start=%b rdy=%b v=%b ord=%0d exp 1/0/0/1", po_filt_start_c_load, po_audio_tready, po_filt_tvalid, po_filt_ord);
    end
    tick();
    for (int b = 0; b < 2; b++) begin
      checks++;
      if ({po_filt_tvalid, po_filt_tlast, po_audio_tready, po_filt_tdata} !== {1'b1, (b == 1), 1'b0, coef[b]}) begin
        failures++; $display("FAIL drain_load%0d got v=%b l=%b rdy=%b d=%h exp d=%h", b, po_filt_tvalid, po_filt_tlast, po_audio_tready, po_filt_tdata, coef[b]);
      end
      tick();
    end
    pi_filt_lddone = 1'b1;
    #1;
    checks++;
    if ({po_filt_tvalid, po_audio_tready} !== 2'b00) begin
      failures++; $display("FAIL drain_wait got v/rdy=%b exp=00", {po_filt_tvalid, po_audio_tready});
    end
    tick();
    pi_filt_lddone = 1'b0;
    checks++;
    if ({po_cfg_done, po_audio_tready, po_filt_tdata} !== {2'b11, 16'h0200}) begin
      failures++; $display("FAIL drain_run got done=%b rdy=%b d=%h exp 1/1/0200", po_cfg_done, po_audio_tready, po_filt_tdata);
    end
    pi_audio_tvalid = 1'b0;
  endtask

  task automatic test_err_in_run();
    pi_filt_ord = 10'd1; pi_reload = 1'b1; pi_filt_err = 1'b1;
    tick();
    pi_reload = 1'b0; pi_filt_err = 1'b0; pi_audio_tvalid = 1'b1;
    #1;
    checks++;
    if ({po_err, po_busy, po_filt_start_c_load, po_audio_tready} !== 4'b1000) begin
      failures++; $display("FAIL run_err got err/busy/start/rdy=%b exp=1000", {po_err, po_busy, po_filt_start_c_load, po_audio_tready});
    end
    tick();
    checks++;
    if ({po_err, po_filt_start_c_load} !== 2'b10) begin
      failures++; $display("FAIL run_err_drop got err/start=%b exp=10", {po_err, po_filt_start_c_load});
    end
    pi_audio_tvalid = 1'b0;
  endtask

  task automatic test_max_order();
    int last_idx;
    last_idx = -1;
    pi_filt_ord = 10'd511; pi_reload = 1'b1;
    tick();
    pi_reload = 1'b0;
    checks++;
    if ({po_filt_start_c_load, po_err, po_filt_ord} !== {2'b10, 10'd511}) begin
      failures++; $display("FAIL max_start got start=%b err=%b ord=%0d exp 1/0/511", po_filt_start_c_load, po_err, po_filt_ord);
    end
    tick();
    for (int b = 0; b < 600; b++) begin
      if (po_filt_tvalid === 1'b1 && po_filt_tlast === 1'b1) begin
        last_idx = b;
        break;
      end
      tick();
    end
    checks++;
    if (last_idx != 511) begin
      failures++; $display("FAIL max_tlast got beat=%0d exp=511", last_idx);
    end
    tick();
    pi_filt_err = 1'b1;
    tick();
    pi_filt_err = 1'b0;
    checks++;
    if ({po_err, po_busy, po_cfg_done} !== 3'b100) begin
      failures++; $display("FAIL max_filt_err got err/busy/done=%b exp=100", {po_err, po_busy, po_cfg_done});
    end
  endtask

  task automatic test_timeout();
    pi_filt_ord = 10'd2; pi_reload = 1'b1;
    tick();
    pi_reload = 1'b0;
    checks++;
    if ({po_err, po_filt_start_c_load} !== 2'b01) begin
      failures++; $display("FAIL tmo_start got err/start=%b exp=01", {po_err, po_filt_start_c_load});
    end
    tick();
    for (int b = 0; b < 3; b++) begin
      checks++;
      if ({po_filt_tvalid, po_filt_tlast, po_filt_tdata} !== {1'b1, (b == 2), coef[b]}) begin
        failures++; $display("FAIL tmo_beat%0d got v=%b l=%b d=%h exp d=%h", b, po_filt_tvalid, po_filt_tlast, po_filt_tdata, coef[b]);
      end
      tick();
    end
    repeat (LD_TIMEOUT - 1) tick();
    checks++;
    if ({po_err, po_busy} !== 2'b01) begin
      failures++; $display("FAIL tmo_early got err/busy=%b exp=01", {po_err, po_busy});
    end
    tick();
    checks++;
    if ({po_err, po_busy} !== 2'b10) begin
      failures++; $display("FAIL tmo_expire got err/busy=%b exp=10", {po_err, po_busy});
    end
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] exp_d;
    pi_filt_ord = 10'd3; pi_reload = 1'b1;
    tick();
    pi_reload = 1'b0;
    repeat (3) tick();
    checks++;
    if (po_filt_tdata !== 16'hFFFF) begin
      failures++; $display("FAIL rst_beat2 got=%h exp=ffff", po_filt_tdata);
    end
    #2 pi_sreset = 1'b1;
    #1;
    checks++;
    if ({po_filt_start_c_load, po_busy, po_cfg_done, po_err, po_filt_tvalid, po_filt_tlast, po_audio_tready, po_filt_ord, po_filt_tdata} !== 33'd0) begin
      failures++; $display("FAIL rst_async got v=%b busy=%b ord=%0d d=%h exp all 0", po_filt_tvalid, po_busy, po_filt_ord, po_filt_tdata);
    end
    #3 pi_sreset = 1'b0;
    tick();
    write_coef(9'd4, 16'h0044);
    write_coef(9'd5, 16'h1234);
    pi_filt_ord = 10'd5; pi_reload = 1'b1;
    tick();
    pi_reload = 1'b0;
    pi_cwr_en = 1'b1; pi_cwr_addr = 9'd5; pi_cwr_data = 16'hDEAD;
    tick();
    pi_cwr_en = 1'b0;
    for (int b = 0; b < 6; b++) begin
      exp_d = (b < 4) ? coef[b] : ((b == 4) ? 16'h0044 : 16'h1234);
      checks++;
      if ({po_filt_tvalid, po_filt_tlast, po_filt_tdata} !== {1'b1, (b == 5), exp_d}) begin
        failures++; $display("FAIL rst_reload%0d got v=%b l=%b d=%h exp d=%h", b, po_filt_tvalid, po_filt_tlast, po_filt_tdata, exp_d);
      end
      tick();
    end
    pi_filt_lddone = 1'b1;
    tick();
    pi_filt_lddone = 1'b0;
    checks++;
    if ({po_cfg_done, po_busy} !== 2'b10) begin
      failures++; $display("FAIL rst_reload_done got done/busy=%b exp=10", {po_cfg_done, po_busy});
    end
  endtask

  initial begin
    coef[0] = 16'h0001; coef[1] = 16'h0002; coef[2] = 16'hFFFF; coef[3] = 16'h8000;
    test_reset();
    test_bad_order();
    test_load_basic();
    test_load_stall();
    test_drain();
    test_err_in_run();
    test_max_order();
    test_timeout();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
